// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// Byte-strobe stores are enabled by defining DMEM_BYTE_STROBE_EN (see dmem_responder).
package dmem_pkg;

   localparam int DATA_W = 64;
   localparam int STRB_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   // Legal when doubleword aligned and the word index falls inside the array.
   function automatic logic addr_ok(input logic [DATA_W-1:0] addr, input int unsigned depth);
      logic [DATA_W-1:0] word;
      word = {3'b000, addr[DATA_W-1:3]};
      return (addr[2:0] == 3'b000) && (word < 64'(depth));
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with per-byte write enables and combinational read.
// Contents are not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [STRB_W-1:0] wr_be,
   input  logic [AW-1:0]     wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency, valid/ready both ways.
// Define DMEM_BYTE_STROBE_EN to make stores honour req_wstrb; otherwise stores write the full word.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// BUSY  | request captured, latency counter running down
// RESP  | response held on resp_* until resp_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                write_q, write_d;
   logic                bad_q, bad_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                access;
   logic                wr_en;
   logic [STRB_W-1:0]   wr_be;
   logic [DATA_W-1:0]   rd_data;

   // The access edge is the last BUSY cycle; a reset before it drops the write.
   assign access = (state_q == BUSY) && (cnt_q == 4'd0);
   assign wr_en  = access && write_q && !bad_q;

`ifdef DMEM_BYTE_STROBE_EN
   assign wr_be = wstrb_q;
`else
   logic unused_wstrb;
   assign wr_be        = '1;
   assign unused_wstrb = ^wstrb_q;
`endif

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_be   (wr_be),
      .wr_idx  (idx_q),
      .wr_data (wdata_q),
      .rd_idx  (idx_q),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      bad_d        = bad_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d     = req_write;
               bad_d       = !addr_ok(req_addr, DEPTH);
               idx_d       = req_addr[3+AW-1:3];
               wdata_d     = req_wdata;
               wstrb_d     = req_wstrb;
               cnt_d       = LAT_LOAD;
               req_ready_d = 1'b0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               rdata_d      = (write_q || bad_q) ? '0 : rd_data;
               err_d        = bad_q;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               rdata_d      = '0;
               err_d        = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            rdata_d      = '0;
            err_d        = 1'b0;
            req_ready_d  = 1'b1;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         bad_q        <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         bad_q        <= bad_d;
         idx_q        <= idx_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
